// File: rtl/debug_uart_tx.sv
// debug_uart_tx: byte FIFO in front of an 8N1 UART transmitter for debug output.
// Bytes are queued with a single-cycle push strobe. The transmitter drains the
// FIFO one frame at a time. The serial line and busy flag are registered one
// cycle behind the FSM state.
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          debug_send,
    input  logic [7:0]                    debug_data,
    input  logic                          clear_overflow,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [1:0]                    tx_state_mon
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          push;
    logic          pop;
    logic          baud_last;

    // Push handshake: debug_send is a valid-only strobe; the implied ready is
    // !fifo_full. A byte offered while full is dropped and flagged in overflow.
    // The pop side is internal: the FSM takes the head byte whenever it is idle
    // and the FIFO is non-empty.
    assign fifo_full    = (level == LEVEL_FULL);
    assign fifo_empty   = (level == '0);
    assign fifo_level   = level;
    assign tx_state_mon = state;
    assign push         = debug_send & ~fifo_full;
    assign pop          = (state == ST_IDLE) & ~fifo_empty;
    assign baud_last    = (baud_cnt == BAUD_LAST);

    // FIFO storage write; contents need no reset because level gates all reads.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= debug_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (debug_send && fifo_full) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Transmit FSM with baud and bit counters; the baud counter is held at 0 in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered line and busy outputs, one cycle behind the FSM so that busy
    // falls exactly when the stop bit ends on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx <= 1'b1;
            busy    <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE) | ~fifo_empty;
            case (state)
                ST_START: uart_tx <= 1'b0;
                ST_DATA:  uart_tx <= shreg[0];
                default:  uart_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx: directed bench for debug_uart_tx with a serial-line
// monitor that decodes frames and checks them against an expected byte queue.
module tb_debug_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       debug_send;
    logic [7:0] debug_data;
    logic       clear_overflow;
    logic       uart_tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [1:0] tx_state_mon;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .debug_send     (debug_send),
        .debug_data     (debug_data),
        .clear_overflow (clear_overflow),
        .uart_tx        (uart_tx),
        .busy           (busy),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .tx_state_mon   (tx_state_mon)
    );

    // clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: present a byte for exactly one rising edge; returns 1 ns after it
    task automatic push(input logic [7:0] b);
        debug_send = 1'b1;
        debug_data = b;
        @(posedge clk);
        #1;
        debug_send = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) until every expected byte has been seen and the block is idle
    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // wait (bounded) for an IDLE cycle that will pop, with the given level
    task automatic wait_idle_level(input string name, input int lvl);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (tx_state_mon == 2'd0 && int'(fifo_level) == lvl) begin
                found = 1'b1;
                break;
            end
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    // monitor: captures 40 line samples from each start bit and decodes the frame
    logic [39:0] cap;
    int          cap_idx = 0;
    bit          cap_on  = 1'b0;

    task automatic decode_frame();
        logic [7:0] b;
        bit         ok;
        ok = 1'b1;
        b  = '0;
        for (int i = 0; i < 4; i++) if (cap[i] !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b[i] = cap[4 + 4 * i];
            for (int j = 1; j < 4; j++) if (cap[4 + 4 * i + j] !== b[i]) ok = 1'b0;
        end
        for (int i = 36; i < 40; i++) if (cap[i] !== 1'b1) ok = 1'b0;
        check("frame_shape", {31'd0, ok}, 32'd1);
        if (exp_q.size() == 0) begin
            check("frame_unexpected", exp_q.size(), 32'd1);
        end else begin
            check("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cap_on = 1'b0;
        end else if (!cap_on) begin
            if (uart_tx === 1'b0) begin
                cap_on  = 1'b1;
                cap[0]  = 1'b0;
                cap_idx = 1;
                start_q.push_back(cyc);
            end
        end else begin
            cap[cap_idx] = uart_tx;
            cap_idx++;
            if (cap_idx == 40) begin
                cap_on = 1'b0;
                decode_frame();
            end
        end
    end

    int n;
    logic [7:0] dbg_str [4];

    initial begin
        reset          = 1'b1;
        debug_send     = 1'b0;
        debug_data     = '0;
        clear_overflow = 1'b0;
        dbg_str[0] = 8'h44; dbg_str[1] = 8'h42; dbg_str[2] = 8'h47; dbg_str[3] = 8'h3A;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_empty", {31'd0, fifo_empty}, 32'd1);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_state", {30'd0, tx_state_mon}, 32'd0);
        reset = 1'b0;
        step();

        // single byte 0x44: start bit from N+2, line high from N+38, busy falls at N+42
        start_q.delete();
        exp_q.push_back(8'h44);
        push(8'h44);
        n = cyc;
        check("t1_level_after_push", {29'd0, fifo_level}, 32'd1);
        for (int k = 1; k <= 42; k++) begin
            step();
            if (k == 1) check("t1_state_start", {30'd0, tx_state_mon}, 32'd1);
            if (k == 1) check("t1_popped", {31'd0, fifo_empty}, 32'd1);
            if (k == 1) check("t1_idle_line", {31'd0, uart_tx}, 32'd1);
            if (k == 2) check("t1_start_first", {31'd0, uart_tx}, 32'd0);
            if (k == 5) check("t1_start_last", {31'd0, uart_tx}, 32'd0);
            if (k == 6) check("t1_bit0", {31'd0, uart_tx}, 32'd0);
            if (k == 14) check("t1_bit2", {31'd0, uart_tx}, 32'd1);
            if (k == 30) check("t1_bit6", {31'd0, uart_tx}, 32'd1);
            if (k == 37) check("t1_bit7", {31'd0, uart_tx}, 32'd0);
            if (k == 38) check("t1_stop", {31'd0, uart_tx}, 32'd1);
            if (k == 41) check("t1_busy_in_stop", {31'd0, busy}, 32'd1);
            if (k == 42) check("t1_busy_fall", {31'd0, busy}, 32'd0);
        end
        check("t1_frames", start_q.size(), 32'd1);
        if (start_q.size() > 0) check("t1_start_edge", start_q[0], n + 2);
        drain("t1_drain");

        // back-to-back "DBG:" -> 41 cycles start-to-start
        start_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(dbg_str[i]);
            push(dbg_str[i]);
        end
        check("t2_overflow", {31'd0, overflow}, 32'd0);
        drain("t2_drain");
        check("t2_frames", start_q.size(), 32'd4);
        for (int k = 0; k + 1 < start_q.size(); k++) begin
            check("t2_spacing", start_q[k + 1] - start_q[k], 32'd41);
        end
        check("t2_overflow_end", {31'd0, overflow}, 32'd0);

        // overflow: 6 pushes, 0x05 dropped
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'(i));
            push(8'(i));
        end
        check("t3_overflow_set", {31'd0, overflow}, 32'd1);
        check("t3_full", {31'd0, fifo_full}, 32'd1);
        check("t3_level", {29'd0, fifo_level}, 32'd4);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("t3_overflow_clear", {31'd0, overflow}, 32'd0);

        // push coinciding with pop: level 4 -> dropped, level 3 -> accepted
        wait_idle_level("t4_wait_full_idle", 4);
        push(8'h06);
        check("t4_full_drop_overflow", {31'd0, overflow}, 32'd1);
        check("t4_full_drop_level", {29'd0, fifo_level}, 32'd3);
        wait_idle_level("t4_wait_l3_idle", 3);
        exp_q.push_back(8'h07);
        push(8'h07);
        check("t4_l3_level", {29'd0, fifo_level}, 32'd3);
        drain("t4_drain");
        check("t4_level_end", {29'd0, fifo_level}, 32'd0);

        // reset during data bit 3 of 0xA5 (overflow still set from above)
        push(8'hA5);
        n = cyc - 1;
        push(8'h5A);
        n = n + 1;
        while (cyc < n + 18) step();
        check("t5_bit3_before_reset", {31'd0, uart_tx}, 32'd0);
        reset      = 1'b1;
        debug_send = 1'b1;
        debug_data = 8'hEE;
        step();
        check("t5_line_high", {31'd0, uart_tx}, 32'd1);
        check("t5_empty", {31'd0, fifo_empty}, 32'd1);
        check("t5_state_idle", {30'd0, tx_state_mon}, 32'd0);
        check("t5_overflow_reset", {31'd0, overflow}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        step();
        check("t5_send_ignored", {29'd0, fifo_level}, 32'd0);
        reset      = 1'b0;
        debug_send = 1'b0;
        start_q.delete();
        repeat (60) step();
        check("t5_no_frame", start_q.size(), 32'd0);
        check("t5_line_idle", {31'd0, uart_tx}, 32'd1);

        // pointer wrap: 10 bytes in groups of 3
        begin
            int i;
            i = 0;
            while (i < 10) begin
                for (int j = 0; j < 3 && i < 10; j++) begin
                    exp_q.push_back(8'(8'h10 + i));
                    push(8'(8'h10 + i));
                    i++;
                end
                drain("t6_drain");
            end
        end
        check("t6_level_end", {29'd0, fifo_level}, 32'd0);
        check("t6_empty_end", {31'd0, fifo_empty}, 32'd1);

        check("leftover_expected", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
